// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: serializes BYTES bytes of a 32-bit word as back-to-back 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after each byte (8E1).
`timescale 1ns/1ps
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int BYTES        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        valid,
  output logic        ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] CPB_M1    = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES - 1);

  state_t      state_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q;
  logic [1:0]  byte_q;
  logic [31:0] sh_q;
  logic        tx_q, ready_q, busy_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CPB_M1);

  // Bit-period counter idles at zero and restarts every bit boundary.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (state_q == IDLE || bit_end) cnt_d = 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      sh_q    <= 32'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      case (state_q)
        IDLE: if (valid && ready_q) begin
          sh_q    <= data_in;
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
          bit_q   <= 3'd0;
          byte_q  <= 2'd0;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
`ifdef UART_TX_PARITY_EN
          par_q   <= ^sh_q[7:0];
`endif
        end
        DATA: if (bit_end) begin
          // Shifting on every data bit leaves the next byte in sh_q[7:0].
          sh_q  <= sh_q >> 1;
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            tx_q <= sh_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          if (byte_q == LAST_BYTE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            byte_q  <= 2'd0;
          end else begin
            state_q <= START;
            tx_q    <= 1'b0;
            byte_q  <= byte_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: 4-byte instance at 4 clks/bit plus a 1-byte instance at 2 clks/bit.
`timescale 1ns/1ps
module tb_uart_word_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
  localparam logic [10:0] PAT1 = 11'b10010101010;
`else
  localparam int F = 10;
  localparam logic [10:0] PAT1 = 11'b01010101010;
`endif
  localparam int NCYC = 4 * F * CPB;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] data_in = 32'd0, data1 = 32'd0;
  logic        valid = 1'b0, valid1 = 1'b0;
  logic        ready, tx, busy, done;
  logic        ready1, tx1, busy1, done1;
  int checks = 0, errors = 0;

  uart_word_tx #(.CLKS_PER_BIT(CPB), .BYTES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done));

  uart_word_tx #(.CLKS_PER_BIT(2), .BYTES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  par;       // even parity of byte k in bit k
    logic        keep;      // hold valid high during the transfer
    logic [31:0] nxt;       // data_in presented after acceptance
    int          late_at;
    logic [31:0] late_word;
    int          abort_at;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic exp_tx(input logic [31:0] w, input logic [3:0] p, input int c);
    int fb, pos;
    fb  = c / (F * CPB);
    pos = (c % (F * CPB)) / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return w[8*fb + pos - 1];
    if (F == 11 && pos == 9) return p[fb];
    return 1'b1;
  endfunction

  // Starts at a negedge with the DUT ready; returns at the done-cycle negedge.
  task automatic run(input vec_t v, input int idx);
    chk($sformatf("v%0d ready_pre", idx), ready, 1);
    data_in = v.word;
    valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid   = v.keep;
    data_in = v.nxt;
    for (int c = 0; c < NCYC; c++) begin
      if (c == v.late_at) data_in = v.late_word;
      if (c == v.abort_at) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("v%0d abort tx", idx), tx, 1);
        chk($sformatf("v%0d abort busy", idx), busy, 0);
        chk($sformatf("v%0d abort done", idx), done, 0);
        return;
      end
      chk($sformatf("v%0d tx c%0d", idx, c), tx, exp_tx(v.word, v.par, c));
      chk($sformatf("v%0d busy c%0d", idx, c), busy, 1);
      chk($sformatf("v%0d ready c%0d", idx, c), ready, 0);
      chk($sformatf("v%0d done c%0d", idx, c), done, 0);
      @(negedge clk);
    end
    chk($sformatf("v%0d done_pulse", idx), done, 1);
    chk($sformatf("v%0d ready_done", idx), ready, 1);
    chk($sformatf("v%0d busy_done", idx), busy, 0);
    chk($sformatf("v%0d tx_done", idx), tx, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t va, vc;
    vecs[0] = '{32'h12345678, 4'b0100, 1'b0, 32'h0,        -1, 32'h0,        -1};
    vecs[1] = '{32'hA5A5A5A5, 4'b0000, 1'b1, 32'h0000FFFF, -1, 32'h0,        -1};
    vecs[2] = '{32'h0000FFFF, 4'b0000, 1'b0, 32'h0,        -1, 32'h0,        -1};
    vecs[3] = '{32'h00000000, 4'b0000, 1'b0, 32'h0,        20, 32'hFFFFFFFF, -1};
    vecs[4] = '{32'h00000107, 4'b0011, 1'b0, 32'h0,        -1, 32'h0,        -1};
    va      = '{32'hDEADBEEF, 4'b0000, 1'b0, 32'h0,        -1, 32'h0,        50};
    vc      = '{32'h000000C3, 4'b0000, 1'b0, 32'h0,        -1, 32'h0,        -1};

    repeat (2) @(negedge clk);
    chk("rst tx", tx, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", ready, 1);

    for (int i = 0; i < 5; i++) run(vecs[i], i);

    run(va, 5);
    @(negedge clk);
    chk("abort hold tx", tx, 1);
    chk("abort hold done", done, 0);
    rst_n = 1'b1;
    run(vc, 6);

    @(negedge clk);
    chk("u1 ready_pre", ready1, 1);
    data1  = 32'h00000055;
    valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 0; c < F * 2; c++) begin
      chk($sformatf("u1 tx c%0d", c), tx1, PAT1[c/2]);
      chk($sformatf("u1 busy c%0d", c), busy1, 1);
      @(negedge clk);
    end
    chk("u1 done_pulse", done1, 1);
    chk("u1 ready_done", ready1, 1);
    @(negedge clk);
    chk("u1 done_single", done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter BYTES, default 4, meaning bytes serialized per accepted word; legal range 1..4.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  32  word to transmit, sampled only on acceptance.
REQ-006 SHALL have port valid  input  1  data_in holds a word to send.
REQ-007 SHALL have port ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high, 8N1 framing.
REQ-009 SHALL have port busy  output  1  word transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of a word transfer.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 SHALL assert ready only in IDLE; acceptance occurs when valid && ready on a posedge.
REQ-013 SHALL latch data_in into an internal shift register on acceptance; later changes to data_in or valid SHALL have no effect until the next acceptance.
REQ-014 SHALL enter START on acceptance and drive tx low from the next cycle for exactly CLKS_PER_BIT cycles.
REQ-015 SHALL send byte k (data_in[8k+7:8k]) for k = 0..BYTES-1 in ascending order; bits within each byte SHALL be sent LSB first, each held for CLKS_PER_BIT cycles.
REQ-016 SHALL send a stop bit (tx high) for CLKS_PER_BIT cycles after each byte, then go directly to START of the next byte with no idle gap.
REQ-017 SHALL frame each byte in 10*CLKS_PER_BIT cycles (11 with the macro), giving BYTES*10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
REQ-018 SHALL return to IDLE after the last stop bit of byte BYTES-1, pulse done for exactly that first IDLE cycle, and assert ready in the same cycle.
REQ-019 SHALL accept a new word in the done cycle when valid is high, so back-to-back words are separated by exactly one idle-high cycle.
REQ-020 SHALL hold busy high from the cycle after acceptance until the last stop-bit cycle inclusive; busy and ready SHALL never be high together.
REQ-021 SHALL use a bit-period counter that counts 0..CLKS_PER_BIT-1 and wraps; the bit index counts 0..7 and the byte index counts 0..BYTES-1, each wrapping without overflow.
REQ-022 SHALL register tx with no combinational path from any input.

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, tx=1, ready=1 (when rst_n high again), busy=0, done=0, and clear all counters and the shift register.
REQ-024 SHALL abort any frame when reset is asserted mid-transfer: no done pulse, and tx is high within the assertion.
REQ-025 SHALL accept a word on the first posedge after rst_n deasserts if valid is high.

Configuration
REQ-026 SHALL, when UART_TX_PARITY_EN is defined, insert a PARITY state after bit 7 of every byte that drives an even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before the stop bit.
REQ-027 SHALL, without UART_TX_PARITY_EN, contain no parity state or logic and follow plain 8N1 framing.

Verification (CLKS_PER_BIT=4, BYTES=4 unless noted)
REQ-028 SHALL cover: accept 0x12345678 -> tx bytes 0x78,0x56,0x34,0x12 LSB first; start bit begins 1 cycle after accept; done pulses at cycle 160 after the first start-bit cycle.
REQ-029 SHALL cover: valid held high with 0xA5A5A5A5 and then 0x0000FFFF -> second start bit exactly 2 cycles after first word's last stop bit ends (done cycle plus 1); ready low throughout each transfer.
REQ-030 SHALL cover: data_in changed to 0xFFFFFFFF at cycle 20 of transfer of 0x00000000 -> tx still sends four 0x00 bytes.
REQ-031 SHALL cover: rst_n pulsed low at cycle 50 of a transfer -> tx=1, busy=0 at once, no done, next word 0x000000C3 sent correctly.
REQ-032 SHALL cover: UART_TX_PARITY_EN defined, word 0x00000107 -> byte 0x07 parity bit 1, byte 0x01 parity 1, bytes 0x00 parity 0; done at cycle 176.
REQ-033 SHALL cover: BYTES=1, CLKS_PER_BIT=2, word 0x55 -> tx pattern 0,1,0,1,0,1,0,1,0,1 each 2 cycles; done at cycle 20.
